// File: rtl/muldiv_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared constants for the HI/LO multiply/divide sequencer:
//             operation codes, FSM state encoding, divider iteration count
//             and a magnitude helper used for signed divide operands.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  typedef logic [2:0] op_t;

  // Operation codes presented by the EX stage (codes 6/7 are no-ops)
  localparam op_t OP_MULT  = 3'd0;
  localparam op_t OP_MULTU = 3'd1;
  localparam op_t OP_DIV   = 3'd2;
  localparam op_t OP_DIVU  = 3'd3;
  localparam op_t OP_MTHI  = 3'd4;
  localparam op_t OP_MTLO  = 3'd5;

  // Sequencer states
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_MUL     = 2'd1;
  localparam logic [1:0] S_DIV_RUN = 2'd2;
  localparam logic [1:0] S_DIV_FIX = 2'd3;

  // Restoring divide iterations, tied to the 32-bit operand width
  localparam int DIV_ITERS = 32;

  // Magnitude of a 32-bit operand; raw value when the operation is unsigned
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? (~v + 32'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : muldiv_ctrl_if
//  Purpose  : EX-stage <-> HI/LO sequencer bundle.
//  Signals  : start, op[2:0], data1[31:0], data2[31:0], mf_req  (EX -> unit)
//             hi[31:0], lo[31:0], busy, done, stall            (unit -> EX)
//  Modports : master (EX stage side), slave (muldiv_ctrl side)
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_ctrl_if;
  import muldiv_pkg::*;

  logic        start;
  op_t         op;
  logic [31:0] data1;
  logic [31:0] data2;
  logic        mf_req;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        stall;

  modport master (
    output start, op, data1, data2, mf_req,
    input  hi, lo, busy, done, stall
  );

  modport slave (
    input  start, op, data1, data2, mf_req,
    output hi, lo, busy, done, stall
  );

endinterface
`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : div_iter
//  Purpose  : Unsigned radix-2 restoring divider core. One quotient bit is
//             produced per 'step'; after WIDTH steps quotient/remainder hold
//             the final unsigned result. Sign handling lives in the caller.
//  Ports    : clk, rst_n (sync, active low)
//             load      - capture dividend/divisor, clear partial remainder
//             step      - perform one restoring iteration
//             dividend  - unsigned dividend   divisor - unsigned divisor
//             quotient  - quotient bits       remainder - partial remainder
//  Revision : 1.0  initial release
// ============================================================================
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dsr_q, dsr_d;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_fits;

  // quo_q starts as the dividend and shifts left; its MSB feeds the partial
  // remainder while the new quotient bit enters at the LSB.
  assign w_trial = {rem_q, quo_q[WIDTH-1]};
  assign w_diff  = w_trial - {1'b0, dsr_q};
  assign w_fits  = (w_trial >= {1'b0, dsr_q});

  always_comb begin
    rem_d = rem_q;
    quo_d = quo_q;
    dsr_d = dsr_q;
    if (load) begin
      rem_d = '0;
      quo_d = dividend;
      dsr_d = divisor;
    end else if (step) begin
      rem_d = w_fits ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
      quo_d = {quo_q[WIDTH-2:0], w_fits};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else begin
      rem_q <= rem_d;
      quo_q <= quo_d;
      dsr_q <= dsr_d;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : muldiv_ctrl
//  Purpose  : HI/LO multiply/divide sequencer. Owns HI and LO, accepts
//             MULT/MULTU/DIV/DIVU/MTHI/MTLO, runs multiplies through a
//             fixed-latency counter and divides through div_iter, and asks
//             the pipeline to stall while a result is pending.
//  Ports    : clk      - core clock
//             rst_n    - synchronous active-low reset
//             bus      - muldiv_ctrl_if.slave (start/op/data1/data2/mf_req in,
//                        hi/lo/busy/done/stall out)
//  Params   : MUL_LAT  - cycles from accepted multiply to HI/LO update (1..15)
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_ctrl_if.slave  bus
);

  localparam int CNT_W = 6;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [63:0]      prod_q,  prod_d;
  logic [31:0]      hi_q,    hi_d;
  logic [31:0]      lo_q,    lo_d;
  logic             done_q,  done_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q,    dz_d;
  logic [31:0]      dvd_q,   dvd_d;

  logic signed [63:0] w_prod_s;
  logic [63:0]        w_prod_u;
  logic [63:0]        w_prod;
  logic               w_idle;
  logic               w_div_signed;
  logic               w_div_load;
  logic               w_div_step;
  logic [31:0]        w_quo;
  logic [31:0]        w_rem;
  logic [31:0]        w_quo_fix;
  logic [31:0]        w_rem_fix;

  assign w_idle   = (state_q == S_IDLE);
  assign w_prod_s = $signed({{32{bus.data1[31]}}, bus.data1}) *
                    $signed({{32{bus.data2[31]}}, bus.data2});
  assign w_prod_u = {32'd0, bus.data1} * {32'd0, bus.data2};
  assign w_prod   = (bus.op == OP_MULT) ? $unsigned(w_prod_s) : w_prod_u;

  assign w_div_signed = (bus.op == OP_DIV);
  assign w_div_load   = w_idle && bus.start && ((bus.op == OP_DIV) || (bus.op == OP_DIVU));
  assign w_div_step   = (state_q == S_DIV_RUN);

  div_iter #(
    .WIDTH (DIV_ITERS)
  ) u_div_iter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (w_div_load),
    .step      (w_div_step),
    .dividend  (mag32(bus.data1, w_div_signed)),
    .divisor   (mag32(bus.data2, w_div_signed)),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // 0x80000000 / -1 needs no special case: |a|/|b| = 0x80000000 with a
  // positive quotient sign, which is exactly the wrapped result required.
  assign w_quo_fix = q_neg_q ? (~w_quo + 32'd1) : w_quo;
  assign w_rem_fix = r_neg_q ? (~w_rem + 32'd1) : w_rem;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    dvd_d   = dvd_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_MULT, OP_MULTU: begin
              if (MUL_LAT == 1) begin
                hi_d   = w_prod[63:32];
                lo_d   = w_prod[31:0];
                done_d = 1'b1;
              end else begin
                prod_d  = w_prod;
                cnt_d   = CNT_W'(MUL_LAT - 1);
                state_d = S_MUL;
              end
            end
            OP_DIV, OP_DIVU: begin
              q_neg_d = w_div_signed & (bus.data1[31] ^ bus.data2[31]);
              r_neg_d = w_div_signed & bus.data1[31];
              dz_d    = (bus.data2 == 32'd0);
              dvd_d   = bus.data1;
              cnt_d   = '0;
              state_d = S_DIV_RUN;
            end
            OP_MTHI: hi_d = bus.data1;
            OP_MTLO: lo_d = bus.data1;
            default: ;
          endcase
        end
      end
      S_MUL: begin
        if (cnt_q == '0) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DIV_RUN: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERS - 1)) begin
          state_d = S_DIV_FIX;
        end
      end
      S_DIV_FIX: begin
        // Divide by zero reports the untouched dividend and an all-ones quotient
        hi_d    = dz_q ? dvd_q : w_rem_fix;
        lo_d    = dz_q ? 32'hFFFF_FFFF : w_quo_fix;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
      dvd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
      dvd_q   <= dvd_d;
    end
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign bus.busy  = !w_idle;
  assign bus.done  = done_q;
  assign bus.stall = !w_idle && (bus.start || bus.mf_req);

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_muldiv_ctrl
//  Purpose  : Self-checking bench for muldiv_ctrl. A latency-based reference
//             model predicts hi/lo/busy/done/stall every cycle from plain
//             arithmetic; directed cases pin the model with literal values,
//             then randomized operation streams exercise the unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  muldiv_ctrl_if bus();

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
  bit          m_busy = 1'b0, m_done = 1'b0, chk_en = 1'b0;
  int          m_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of a mult/div op from plain integer arithmetic
  function automatic void ref_result(input logic [2:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] h, output logic [31:0] l);
    longint          sa, sb, p, q, r;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    h = '0;
    l = '0;
    case (op)
      OP_MULT:  begin p = sa * sb;  h = p[63:32];  l = p[31:0];  end
      OP_MULTU: begin pu = ua * ub; h = pu[63:32]; l = pu[31:0]; end
      OP_DIV: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin q = sa / sb; r = sa % sb; h = r[31:0]; l = q[31:0]; end
      end
      OP_DIVU: begin
        if (b == 32'd0) begin h = a; l = 32'hFFFF_FFFF; end
        else begin pu = ua / ub; h = 32'(ua % ub); l = pu[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Model: one op at a time, result lands a fixed number of edges after accept
  always @(posedge clk) begin
    if (!rst_n) begin
      m_hi = '0; m_lo = '0; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_hi = r_hi; m_lo = r_lo; m_busy = 1'b0; m_done = 1'b1;
        end
      end else if (bus.start) begin
        case (bus.op)
          OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
            ref_result(bus.op, bus.data1, bus.data2, r_hi, r_lo);
            m_left = (bus.op == OP_MULT || bus.op == OP_MULTU) ? MUL_LAT : DIV_LAT;
            if (m_left == 1) begin
              m_hi = r_hi; m_lo = r_lo; m_done = 1'b1; m_left = 0;
            end else begin
              m_busy = 1'b1;
            end
          end
          OP_MTHI: m_hi = bus.data1;
          OP_MTLO: m_lo = bus.data1;
          default: ;
        endcase
      end
    end
  end

  // Cycle-by-cycle comparison, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hi",    bus.hi, m_hi);
      chk("lo",    bus.lo, m_lo);
      chk("busy",  32'(bus.busy),  32'(m_busy));
      chk("done",  32'(bus.done),  32'(m_done));
      chk("stall", 32'(bus.stall), 32'(m_busy & (bus.start | bus.mf_req)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it (as the EX stage does under stall) until accepted
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit acc;
    acc = 1'b0;
    bus.start = 1'b1; bus.op = op; bus.data1 = a; bus.data2 = b;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      acc = !m_busy;
      step();
      if (acc) break;
    end
    bus.start = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL issue_timeout: op %0d not accepted within 100 cycles", op);
    end
  endtask

  // Count cycles the DUT reports busy; returns at the negedge busy is low
  task automatic busy_cycles(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) break;
      n++;
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (m_busy && k < 200) begin step(); k++; end
    if (m_busy) begin
      checks++; errors++;
      $display("FAIL idle_timeout: model still busy after 200 cycles");
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    int n;
    bus.start = 1'b0; bus.op = '0; bus.data1 = '0; bus.data2 = '0; bus.mf_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Multiplies
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    busy_cycles(n);
    chk("mult_lat",  32'(n), 32'd4);
    chk("mult_hi",   bus.hi, 32'hFFFF_FFFF);
    chk("mult_lo",   bus.lo, 32'hFFFF_FFFE);
    chk("mult_done", 32'(bus.done), 32'h1);
    step();
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    busy_cycles(n);
    chk("multu_hi", bus.hi, 32'h0000_0001);
    chk("multu_lo", bus.lo, 32'hFFFF_FFFE);
    step();

    // Divides
    issue(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    busy_cycles(n);
    chk("div_lat", 32'(n), 32'd33);
    chk("div_lo",  bus.lo, 32'hFFFF_FFFD);
    chk("div_hi",  bus.hi, 32'hFFFF_FFFF);
    step();
    issue(OP_DIVU, 32'h0000_0007, 32'h0000_0000);
    busy_cycles(n);
    chk("divz_lat", 32'(n), 32'd33);
    chk("divz_hi",  bus.hi, 32'h0000_0007);
    chk("divz_lo",  bus.lo, 32'hFFFF_FFFF);
    step();
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    busy_cycles(n);
    chk("ovf_lo", bus.lo, 32'h8000_0000);
    chk("ovf_hi", bus.hi, 32'h0000_0000);
    step();

    // mf_req and a held start during a divide
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (4) step();
    bus.mf_req = 1'b1;
    repeat (5) step();
    issue(OP_MULT, 32'd3, 32'd4);
    chk("mfhi_rem", bus.hi, 32'd2);
    chk("mflo_quo", bus.lo, 32'd14);
    bus.mf_req = 1'b0;
    busy_cycles(n);
    chk("held_mult_lat", 32'(n), 32'd4);
    chk("held_mult_lo",  bus.lo, 32'd12);
    step();

    // MTHI / MTLO back to back, then read-before-write
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi", bus.hi, 32'h1234_5678);
    issue(OP_MTLO, 32'h9ABC_DEF0, 32'h0);
    chk("mtlo", bus.lo, 32'h9ABC_DEF0);
    chk("mt_busy", 32'(bus.busy), 32'h0);
    bus.mf_req = 1'b1; bus.start = 1'b1; bus.op = OP_MTHI; bus.data1 = 32'hCAFE_F00D;
    @(negedge clk);
    chk("rbw_hi",    bus.hi, 32'h1234_5678);
    chk("rbw_stall", 32'(bus.stall), 32'h0);
    step();
    bus.start = 1'b0; bus.mf_req = 1'b0;
    chk("mthi2", bus.hi, 32'hCAFE_F00D);

    // Reset in the middle of a divide
    issue(OP_DIV, 32'd1000, 32'd3);
    repeat (16) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_hi",   bus.hi, 32'h0);
    chk("mid_rst_lo",   bus.lo, 32'h0);
    chk("mid_rst_busy", 32'(bus.busy), 32'h0);
    chk("mid_rst_done", 32'(bus.done), 32'h0);
    step();
    issue(OP_MULTU, 32'd3, 32'd5);
    busy_cycles(n);
    chk("post_rst_lat", 32'(n), 32'd4);
    chk("post_rst_lo",  bus.lo, 32'd15);
    chk("post_rst_hi",  bus.hi, 32'd0);
    step();

    // Randomized op stream with mf_req noise and occasional resets
    for (int t = 0; t < 300; t++) begin
      bus.mf_req = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), pick(), pick());
      repeat ($urandom_range(0, 3)) begin
        bus.mf_req = 1'($urandom_range(0, 1));
        step();
      end
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
    end
    bus.mf_req = 1'b0;
    wait_idle();
    repeat (2) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
